alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operand bundle valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a bundle this cycle.
REQ-006 SHALL have ports in_a and in_b  input  32 each  operands.
REQ-007 SHALL have port in_op  input  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 100 NOR, 101 XOR, 110 SUB.
REQ-008 SHALL have port in_unsig  input  1  1 = unsigned arithmetic, 0 = signed.
REQ-009 SHALL have port out_valid  output  1  registered result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have ports out_result (32), out_compout (1) and out_overflow (1), all outputs, carrying the registered ALU outputs.
REQ-012 SHALL have port ops_done  output  CNT_W  count of completed output handshakes.

Function
REQ-013 SHALL feed in_a, in_b, in_op and in_unsig combinationally into one Alu instance, and register its aluout, compout and overflow on acceptance.
- Acceptance: in_valid && in_ready at a rising edge.
REQ-014 SHALL use a two-state FSM.
- EMPTY → FULL on accept.
- FULL → EMPTY on out_valid && out_ready without a simultaneous accept.
- FULL stays FULL on a simultaneous handshake and accept, loading the new bundle.
REQ-015 SHALL drive in_ready = (state==EMPTY) || out_ready, giving one bundle per cycle throughput.
REQ-016 SHALL have a latency of one cycle: a bundle accepted at edge N is visible on out_* with out_valid=1 after edge N.
REQ-017 SHALL hold out_result, out_compout and out_overflow stable while out_valid && !out_ready.
REQ-018 SHALL register opcodes 011 and 111 with out_result=0, out_compout=0 and out_overflow=0.
REQ-019 SHALL increment ops_done by 1 on each out_valid && out_ready edge, wrapping from 2^CNT_W-1 to 0.
REQ-020 SHALL drop in_valid while in_ready=0 without losing or duplicating any bundle.

Reset
REQ-021 SHALL, at a rising edge with rst_n=0, set state=EMPTY, out_valid=0, out_result=0, out_compout=0, out_overflow=0 and ops_done=0.
REQ-022 SHALL discard any held result when reset is asserted mid-operation, with no handshake counted.
REQ-023 SHALL drive in_ready=0 during reset and allow acceptance from the first edge after rst_n returns to 1.

Configuration
REQ-024 SHALL, when ALU_EXEC_OVF_TRAP_EN is defined, add port trap output 1 and port trap_clr input 1.
- trap sets when a signed (in_unsig=0) ADD or SUB registers overflow=1.
- While trap=1, in_ready=0; the held result still drains normally.
- trap_clr=1 at an edge clears trap; if trap_clr coincides with a new trapping result, the set wins.
REQ-025 SHALL, when ALU_EXEC_OVF_TRAP_EN is undefined, omit trap and trap_clr, and never block on overflow.

Structure
REQ-026 SHALL take opcode constants (OP_AND, OP_OR, OP_ADD, OP_NOR, OP_XOR, OP_SUB) and the FSM state encoding from shared package alu_pkg.
REQ-027 SHALL contain exactly one sub-module, the existing Alu, instantiated once.

Verification
REQ-028 SHALL cover these directed scenarios:
- ADD signed overflow: a=0x7FFFFFFF, b=0x7FFFFFFF, op=010, unsig=0 → next cycle out_result=0xFFFFFFFE, out_overflow=1; with ALU_EXEC_OVF_TRAP_EN, trap=1 and in_ready=0 until trap_clr.
- AND then SUB back-to-back, out_ready=1: a=0x43667107, b=0x0CC64678 → results 0x00464000 then 0x36A02A8F, both overflow=0; ops_done=2.
- Backpressure: out_ready=0 for 3 cycles with a held ADD result → outputs stable, in_ready=0; release → one handshake, then the next bundle is accepted the same cycle.
- Reset while FULL with out_ready=0 → after the edge, out_valid=0, ops_done=0, in_ready=1 once rst_n=1.
- Counter wrap with CNT_W=2: five handshakes → ops_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, stage FSM encoding and opcode helper
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic logic is_addsub(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU; unknown opcodes (011, 111) yield all-zero outputs
// compout is the a<b comparison from SUB; overflow is only reported for signed ADD/SUB.
module Alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   input  logic        unsig,
   output logic [31:0] aluout,
   output logic        compout,
   output logic        overflow
);

   logic [31:0] sum;
   logic [32:0] diff;
   logic        add_ovf;
   logic        sub_ovf;

   always_comb begin
      sum     = a + b;
      diff    = {1'b0, a} - {1'b0, b};
      add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
   end

   always_comb begin
      aluout   = 32'd0;
      compout  = 1'b0;
      overflow = 1'b0;
      case (op)
         OP_AND: aluout = a & b;
         OP_OR:  aluout = a | b;
         OP_NOR: aluout = ~(a | b);
         OP_XOR: aluout = a ^ b;
         OP_ADD: begin
            aluout   = sum;
            overflow = !unsig && add_ovf;
         end
         OP_SUB: begin
            aluout   = diff[31:0];
            overflow = !unsig && sub_ovf;
            // unsigned less-than is the borrow; signed is sign corrected by overflow
            compout  = unsig ? diff[32] : (diff[31] ^ sub_ovf);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - one-entry registered ALU execute stage with valid/ready handshakes
// Optional overflow trap enabled by defining ALU_EXEC_OVF_TRAP_EN.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [2:0]       in_op,
   input  logic             in_unsig,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_compout,
   output logic             out_overflow,
   output logic [CNT_W-1:0] ops_done
`ifdef ALU_EXEC_OVF_TRAP_EN
   ,
   output logic             trap,
   input  logic             trap_clr
`endif
);

   logic [31:0] alu_out;
   logic        alu_comp;
   logic        alu_ovf;
   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        drain;
   logic        blocked;

   Alu u_alu (
      .a        (in_a),
      .b        (in_b),
      .op       (in_op),
      .unsig    (in_unsig),
      .aluout   (alu_out),
      .compout  (alu_comp),
      .overflow (alu_ovf)
   );

`ifdef ALU_EXEC_OVF_TRAP_EN
   assign blocked = trap;

   // a new trapping result outranks a simultaneous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trap <= 1'b0;
      end else if (accept && alu_ovf && !in_unsig && is_addsub(in_op)) begin
         trap <= 1'b1;
      end else if (trap_clr) begin
         trap <= 1'b0;
      end
   end
`else
   assign blocked = 1'b0;
`endif

   always_comb begin
      out_valid = (state == ST_FULL);
      in_ready  = rst_n && !blocked && ((state == ST_EMPTY) || out_ready);
      drain     = out_valid && out_ready;
      accept    = in_valid && in_ready;
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_FULL;
         ST_FULL:  if (drain && !accept) state_nxt = ST_EMPTY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_EMPTY;
         out_result   <= 32'd0;
         out_compout  <= 1'b0;
         out_overflow <= 1'b0;
         ops_done     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            out_result   <= alu_out;
            out_compout  <= alu_comp;
            out_overflow <= alu_ovf;
         end
         if (drain) begin
            ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage (CNT_W=16 and CNT_W=2)
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  in_op;
   logic        in_unsig;
   logic        out_ready;

   logic        in_ready,  in_ready2;
   logic        out_valid, out_valid2;
   logic [31:0] out_result, out_result2;
   logic        out_compout, out_compout2;
   logic        out_overflow, out_overflow2;
   logic [15:0] ops_done;
   logic [1:0]  ops_done2;
`ifdef ALU_EXEC_OVF_TRAP_EN
   logic        trap, trap2;
   logic        trap_clr;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] va [6];
   logic [31:0] vb [6];
   logic [2:0]  vo [6];
   logic        vu [6];
   logic [31:0] vr [6];
   logic        vc [6];

   always #5 clk = ~clk;

   alu_exec_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_unsig(in_unsig),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_compout(out_compout), .out_overflow(out_overflow), .ops_done(ops_done)
`ifdef ALU_EXEC_OVF_TRAP_EN
      , .trap(trap), .trap_clr(trap_clr)
`endif
   );

   alu_exec_stage #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_unsig(in_unsig),
      .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
      .out_compout(out_compout2), .out_overflow(out_overflow2), .ops_done(ops_done2)
`ifdef ALU_EXEC_OVF_TRAP_EN
      , .trap(trap2), .trap_clr(trap_clr)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic u);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_unsig = u;
   endtask

   initial begin
      va[0] = 32'h12340000; vb[0] = 32'h00005678; vo[0] = 3'b001; vu[0] = 1'b0; vr[0] = 32'h12345678; vc[0] = 1'b0;
      va[1] = 32'hFFFF0000; vb[1] = 32'h000000FF; vo[1] = 3'b100; vu[1] = 1'b0; vr[1] = 32'h0000FF00; vc[1] = 1'b0;
      va[2] = 32'h00000005; vb[2] = 32'h00000003; vo[2] = 3'b011; vu[2] = 1'b0; vr[2] = 32'h00000000; vc[2] = 1'b0;
      va[3] = 32'h00000001; vb[3] = 32'h00000002; vo[3] = 3'b110; vu[3] = 1'b1; vr[3] = 32'hFFFFFFFF; vc[3] = 1'b1;
      va[4] = 32'hFFFFFFFF; vb[4] = 32'hFFFFFFFF; vo[4] = 3'b111; vu[4] = 1'b0; vr[4] = 32'h00000000; vc[4] = 1'b0;
      va[5] = 32'hFFFFFFFF; vb[5] = 32'h00000001; vo[5] = 3'b110; vu[5] = 1'b0; vr[5] = 32'hFFFFFFFE; vc[5] = 1'b1;

      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 3'b000, 1'b0);
`ifdef ALU_EXEC_OVF_TRAP_EN
      trap_clr = 1'b0;
`endif
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ops_done", ops_done, 0);
      chk("rst_result", out_result, 0);
      chk("rst_overflow", out_overflow, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // AND then SUB back-to-back
      out_ready = 1'b1;
      drive(1'b1, 32'h43667107, 32'h0CC64678, 3'b000, 1'b0);
      step();
      chk("and_valid", out_valid, 1);
      chk("and_result", out_result, 32'h00464000);
      chk("and_ovf", out_overflow, 0);
      drive(1'b1, 32'h43667107, 32'h0CC64678, 3'b110, 1'b0);
      step();
      chk("sub_result", out_result, 32'h36A02A8F);
      chk("sub_ovf", out_overflow, 0);
      chk("sub_comp", out_compout, 0);
      chk("sub_ops_done", ops_done, 1);
      in_valid = 1'b0;
      step();
      chk("b2b_ops_done", ops_done, 2);
      chk("b2b_drained", out_valid, 0);

      // signed ADD overflow, then held under backpressure
      out_ready = 1'b0;
      drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0);
      step();
      in_valid = 1'b0;
      #1;
      chk("add_result", out_result, 32'hFFFFFFFE);
      chk("add_ovf", out_overflow, 1);
      chk("add_valid", out_valid, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_result", out_result, 32'hFFFFFFFE);
         chk("bp_ovf", out_overflow, 1);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      drive(1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b101, 1'b0);
      out_ready = 1'b1;
      #1;
`ifdef ALU_EXEC_OVF_TRAP_EN
      chk("trap_set", trap, 1);
      chk("trap_in_ready", in_ready, 0);
      step();
      chk("trap_drain_ops", ops_done, 3);
      chk("trap_drain_valid", out_valid, 0);
      chk("trap_held", trap, 1);
      trap_clr = 1'b1;
      step();
      chk("trap_cleared", trap, 0);
      chk("trap_no_accept", out_valid, 0);
      trap_clr = 1'b0;
      #1;
      chk("trap_ready_again", in_ready, 1);
      step();
`else
      chk("release_in_ready", in_ready, 1);
      step();
      chk("release_ops_done", ops_done, 3);
`endif
      chk("xor_valid", out_valid, 1);
      chk("xor_result", out_result, 32'hFF00FF00);
      chk("xor_ovf", out_overflow, 0);

      // reset while FULL and stalled
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      step();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ops", ops_done, 0);
      chk("midrst_ops2", ops_done2, 0);
      chk("midrst_result", out_result, 0);
      chk("midrst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("midrst_in_ready_after", in_ready, 1);

      // streaming vectors; CNT_W=2 copy wraps 1,2,3,0,1,2
      out_ready = 1'b1;
      for (int j = 0; j < 7; j++) begin
         if (j < 6) drive(1'b1, va[j], vb[j], vo[j], vu[j]);
         else       in_valid = 1'b0;
         step();
         if (j < 6) begin
            chk("vec_valid", out_valid, 1);
            chk("vec_result", out_result, vr[j]);
            chk("vec_comp", out_compout, vc[j]);
            chk("vec_ovf", out_overflow, 0);
         end else begin
            chk("vec_drained", out_valid, 0);
         end
         chk("vec_ops_done", ops_done, j);
         chk("wrap_ops_done2", ops_done2, j % 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
